// File: rtl/lsu_pkg.sv
// lsu_pkg: shared op encodings, FSM states and memory-window defaults for the LSU initiator.
package lsu_pkg;

    localparam logic [2:0] LSU_LW  = 3'd0;
    localparam logic [2:0] LSU_LB  = 3'd1;
    localparam logic [2:0] LSU_LBU = 3'd2;
    localparam logic [2:0] LSU_SW  = 3'd3;
    localparam logic [2:0] LSU_SB  = 3'd4;

    localparam logic [31:0] LSU_MEM_BASE  = 32'hFFFF_FF00;
    localparam int          LSU_MEM_WORDS = 256;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } lsu_state_t;

    function automatic logic lsu_is_legal(input logic [2:0] op);
        return op <= LSU_SB;
    endfunction

    function automatic logic lsu_is_store(input logic [2:0] op);
        return op == LSU_SW || op == LSU_SB;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: load result extension (word, signed byte, unsigned byte); stores and illegal ops give 0.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_data,
    output logic [31:0] o_ext
);

    always_comb
        o_ext = i_op == LSU_LW  ? i_data :
                i_op == LSU_LB  ? {{24{i_data[7]}}, i_data[7:0]} :
                i_op == LSU_LBU ? {24'b0, i_data[7:0]} : '0;

endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: MEM-stage load/store initiator driving a word-addressed data memory.
// Define LSU_RANGE_CHECK_EN to fault requests outside MEM_BASE..MEM_BASE+MEM_WORDS-1.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int          RD_LAT    = 0,
    parameter logic [31:0] MEM_BASE  = LSU_MEM_BASE,
    parameter int          MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_write_eight,
    input  logic [31:0] mem_rdata
);

`ifdef LSU_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    lsu_state_t  r_state;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic [3:0]  r_cnt;
    logic [31:0] w_ext;
    logic        w_in_range;
    logic        w_go;

    // Offset subtraction wraps, so a single unsigned compare covers both window edges.
    assign w_in_range = !RANGE_CHECK || ((req_addr - MEM_BASE) < 32'(MEM_WORDS));
    assign w_go       = lsu_is_legal(req_op) && w_in_range;

    lsu_load_ext u_load_ext (
        .i_op   (r_op),
        .i_data (mem_rdata),
        .o_ext  (w_ext)
    );

    assign req_ready       = r_state == S_IDLE;
    assign stall           = r_state != S_IDLE;
    assign resp_valid      = r_state == S_RESP;
    assign resp_rdata      = r_rdata;
    assign resp_fault      = r_fault;
    assign mem_addr        = r_addr;
    assign mem_wdata       = r_wdata;
    assign mem_write       = r_state == S_ACCESS && r_op == LSU_SW;
    assign mem_write_eight = r_state == S_ACCESS && r_op == LSU_SB;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && w_go) begin
                        r_state <= S_ACCESS;
                        r_op    <= req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                    end else if (req_valid) begin
                        r_state <= S_RESP;
                        r_rdata <= '0;
                        r_fault <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    // Stores resolve to 0 through the extender, so they share the load capture.
                    if (lsu_is_store(r_op) || RD_LAT == 0) begin
                        r_state <= S_RESP;
                        r_rdata <= w_ext;
                        r_fault <= 1'b0;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= 4'(RD_LAT);
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                        r_rdata <= w_ext;
                        r_fault <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: scoreboard bench with a word-array reference model and a behavioural memory.
module tb_lsu_mem_initiator;

    localparam int RD_LAT = 3;
    localparam logic [2:0] OP_LW = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2, OP_SW = 3'd3, OP_SB = 3'd4;
`ifdef LSU_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          nw;
        int          nw8;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready, resp_valid, resp_fault, stall, mem_write, mem_write_eight;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] fix_mem [256];
    logic [31:0] ref_mem [256];
    exp_t        q[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, acc_cyc = 0, nw = 0, nw8 = 0;
    bit          busy = 0;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_write_eight(mem_write_eight), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = fix_mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_write) fix_mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_write_eight) fix_mem[mem_addr[7:0]][7:0] <= mem_wdata[7:0];
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] w);
        int b;
        b = int'(w & 32'hFF);
        if (op == OP_LW) return w;
        if (op == OP_LB) return 32'(b >= 128 ? b - 256 : b);
        return 32'(b);
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return !RC || a >= 32'hFFFF_FF00;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
        exp_t e;
        int   idx;
        bit   ok;
        idx = int'(addr[7:0]);
        e.addr = addr; e.wdata = wdata; e.nw = 0; e.nw8 = 0; e.rdata = '0; e.fault = 1'b0;
        if (op > OP_SB || !in_range(addr)) begin
            e.fault = 1'b1; e.lat = 1;
        end else if (op == OP_SW) begin
            e.lat = 2; e.nw = 1; ref_mem[idx] = wdata;
        end else if (op == OP_SB) begin
            e.lat = 2; e.nw8 = 1; ref_mem[idx][7:0] = wdata[7:0];
        end else begin
            e.lat = 2 + RD_LAT; e.rdata = load_val(op, ref_mem[idx]);
        end
        q.push_back(e);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: op %0d addr %h never accepted", op, addr);
            void'(q.pop_back());
        end
        @(posedge clk); #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                chk("rst_req_ready", 32'(req_ready), 32'd1);
                chk("rst_resp_valid", 32'(resp_valid), 32'd0);
                chk("rst_strobes", 32'({mem_write, mem_write_eight}), 32'd0);
                busy = 0; nw = 0; nw8 = 0;
            end else begin
                chk("stall", 32'(stall), 32'(busy));
                chk("req_ready", 32'(req_ready), 32'(!busy));
                chk("dual_strobe", 32'(mem_write && mem_write_eight), 32'd0);
                if (mem_write || mem_write_eight) begin
                    if (mem_write) nw++;
                    if (mem_write_eight) nw8++;
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL stray_strobe: got strobe with no request outstanding");
                    end else begin
                        chk("mem_addr", mem_addr, q[0].addr);
                        chk("mem_wdata", mem_wdata, q[0].wdata);
                    end
                end
                if (resp_valid) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_resp: got resp_valid with empty scoreboard");
                    end else begin
                        e = q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_fault", 32'(resp_fault), 32'(e.fault));
                        chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                        chk("mem_write_cycles", 32'(nw), 32'(e.nw));
                        chk("mem_write_eight_cycles", 32'(nw8), 32'(e.nw8));
                    end
                    busy = 0; nw = 0; nw8 = 0;
                end
                if (req_valid && req_ready) begin
                    busy = 1; acc_cyc = cyc;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        fork monitor(); join_none
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        issue(OP_SW, 32'hFFFF_FF10, 32'hDEAD_BEEF, 0);
        for (int i = 0; i < 256; i++) issue(OP_SW, 32'hFFFF_FF00 + 32'(i), $urandom, 1);
        issue(OP_SW, 32'hFFFF_FF10, 32'h0000_00F5, 0);
        issue(OP_LB, 32'hFFFF_FF10, 32'h0, 0);
        issue(OP_LBU, 32'hFFFF_FF10, 32'h0, 0);
        issue(OP_LW, 32'hFFFF_FF10, 32'h0, 0);
        issue(OP_SW, 32'hFFFF_FF20, 32'hAAAA_AAAA, 0);
        issue(OP_SB, 32'hFFFF_FF20, 32'h1234_5681, 0);
        issue(OP_LW, 32'hFFFF_FF20, 32'h0, 0);
        for (int i = 0; i < 3; i++) issue(OP_LW, 32'hFFFF_FF20 - 32'(i * 16), 32'h0, 1);
        drain();
        // Reset during a store's ACCESS cycle: strobe must fall with no clock edge and nothing is written.
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'hFFFF_FF30; req_wdata = 32'h5555_5555;
        @(posedge clk); #1 req_valid = 1'b0;
        chk("access_mem_write", 32'(mem_write), 32'd1);
        #1 reset = 1'b1;
        #1 chk("async_mem_write_drop", 32'(mem_write), 32'd0);
        chk("async_stall_drop", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        issue(OP_LW, 32'hFFFF_FF30, 32'h0, 0);
        issue(3'd7, 32'hFFFF_FF40, 32'h0, 0);
        issue(3'd5, 32'hFFFF_FF40, 32'h0, 0);
        issue(OP_SW, 32'h0000_0010, 32'h1111_1111, 0);
        issue(OP_LW, 32'h0000_0010, 32'h0, 0);
        issue(OP_LW, 32'hFFFF_FF10, 32'h0, 0);
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            op = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 15) == 0) ? $urandom : (32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
            issue(op, a, $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        drain();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator on the MEM-stage side of the data memory port.
- Accepts one load or store request from the pipeline through a valid/ready handshake.
- Drives the word-addressed data-memory interface (address, write data, word-write strobe, low-byte-write strobe, combinational read data).
- Sign- or zero-extends byte loads, returns one response per request and stalls the pipeline while an access is in flight.

Parameters:
- RD_LAT, 0: extra cycles to wait after ACCESS before sampling mem_rdata (0..15).
- MEM_BASE, 32'hFFFFFF00: lowest valid word address.
- MEM_WORDS, 256: number of valid word addresses from MEM_BASE upward.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  pipeline request present
- req_ready  out  1  request accepted when valid&ready at clk edge
- req_op  in  3  LSU_LW=0, LSU_LB=1, LSU_LBU=2, LSU_SW=3, LSU_SB=4; others illegal
- req_addr  in  32  word address
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result (0 for stores)
- resp_fault  out  1  access rejected (qualified by resp_valid)
- stall  out  1  pipeline freeze
- mem_addr  out  32  to memory Addr
- mem_wdata  out  32  to memory Wdata
- mem_write  out  1  to memory MemWrite
- mem_write_eight  out  1  to memory MemWriteEight
- mem_rdata  in  32  from memory Rdata, combinational on mem_addr

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP.
- Reset: state=IDLE, all outputs 0 except req_ready=1. Latched op/addr/wdata cleared to 0.
- IDLE:
  - req_ready=1.
  - On req_valid with a legal op, latch op/addr/wdata and go to ACCESS.
  - An illegal op is still accepted; go straight to RESP with resp_fault=1.
- ACCESS:
  - mem_addr and mem_wdata = latched values.
  - SW asserts mem_write for exactly this cycle. SB asserts mem_write_eight for exactly this cycle. Never assert both.
  - Stores go to RESP.
  - Loads with RD_LAT=0 capture mem_rdata at the end of this cycle and go to RESP. Loads with RD_LAT>0 go to WAIT with the counter set to RD_LAT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata at the end of that cycle and go to RESP.
  - mem_addr is held.
- RESP:
  - resp_valid=1 for one cycle, then IDLE. req_ready=0 in this state.
  - Capture data per op: LW gives the word; LB gives {{24{d[7]}},d[7:0]}; LBU gives {24'b0,d[7:0]}; stores give 0.
- req_ready=1 only in IDLE. stall=1 in ACCESS, WAIT and RESP.
- mem_addr and mem_wdata hold their last values in IDLE.
- Latency: store is accept, then ACCESS, then RESP, so resp_valid appears 2 cycles after acceptance. A load takes 2+RD_LAT cycles.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after RESP.
- Write strobes are decoded from registered state only, never from req_* inputs. Reset asserted mid-ACCESS drops the strobes immediately; no response is issued.
- resp_rdata and resp_fault keep their values after RESP until the next RESP.

Optional Feature:
- LSU_RANGE_CHECK_EN defined:
  - At acceptance, check the address against MEM_BASE..MEM_BASE+MEM_WORDS-1.
  - Out-of-range requests skip ACCESS/WAIT, raise no strobes, and go to RESP with resp_fault=1 and resp_rdata=0.
- Undefined:
  - Every legal op is forwarded to memory.
  - resp_fault is 1 only for illegal ops.

Decomposition:
- Shared package lsu_pkg holds:
  - the req_op encodings (LSU_LW..LSU_SB),
  - the state enum,
  - the MEM_BASE/MEM_WORDS defaults.
- One natural sub-module: lsu_load_ext, purely combinational. It takes op and 32-bit data and produces the extended result, and is shared with any future cache path.

Test Plan:
- SW addr FFFFFF10 data DEADBEEF -> mem_write high exactly 1 cycle, mem_write_eight never; resp_valid 2 cycles after accept, rdata 0, fault 0.
- Preload FFFFFF10=000000F5; LB then LBU at FFFFFF10 -> FFFFFFF5 then 000000F5; LW -> 000000F5.
- SB addr FFFFFF20 data 12345681 over 0xAAAAAAAA -> mem_write_eight only, with mem_wdata[7:0]=81; subsequent LW -> AAAAAA81.
- RD_LAT=3, LW -> stall high 5 cycles, resp_valid at accept+5; req_valid held high during the access -> next request accepted the cycle after RESP.
- Reset asserted during ACCESS of SW -> mem_write drops without a clock edge, no resp_valid, req_ready=1 after release.
- With LSU_RANGE_CHECK_EN: SW at 00000010 -> no strobes, resp_fault=1 at accept+1. Separately, with or without the macro: req_op=7 -> fault=1.
